padding_stream: RTL and testbench



---
 rtl/conv_pkg.sv | 19 +
 rtl/padding_pos_cnt.sv | 51 +++++
 rtl/padding_stream.sv | 82 ++++++++
 tb/tb_padding_stream.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared geometry helpers for the convolution path (padder, window generator).
package conv_pkg;

  function automatic int unsigned padded_size(input int unsigned n, input int unsigned p);
    return n + 2 * p;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when (row, col) of the padded frame maps onto a real input pixel.
  function automatic logic is_interior(input int unsigned row, input int unsigned col,
                                       input int unsigned p, input int unsigned w,
                                       input int unsigned h);
    return (row >= p) && (row < p + h) && (col >= p) && (col < p + w);
  endfunction

endpackage

// File: rtl/padding_pos_cnt.sv
// Row/column position of the next pixel to load into the padder output register.
// PADDING_MARKERS_EN adds the first-pixel flag used for start-of-frame marking.
module padding_pos_cnt
  import conv_pkg::*;
#(
  parameter int unsigned W = 220,
  parameter int unsigned H = 220,
  parameter int unsigned P = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic interior_c,
`ifdef PADDING_MARKERS_EN
  output logic first_c,
`endif
  output logic last_col_c,
  output logic last_pixel_c
);

  localparam int unsigned PW = padded_size(W, P);
  localparam int unsigned PH = padded_size(H, P);
  localparam int unsigned CW = cnt_width(PW);
  localparam int unsigned RW = cnt_width(PH);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  assign last_col_c   = (col == CW'(PW - 1));
  assign last_pixel_c = last_col_c && (row == RW'(PH - 1));
  assign interior_c   = is_interior(32'(row), 32'(col), P, W, H);
`ifdef PADDING_MARKERS_EN
  assign first_c      = (col == '0) && (row == '0);
`endif

  // Raster walk over the padded frame; wraps straight into the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (last_col_c) begin
        col <= '0;
        row <= last_pixel_c ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/padding_stream.sv
// Streaming constant-border padder: W x H raster in, (W+2P) x (H+2P) raster out.
// Define PADDING_MARKERS_EN to add out_sof / out_eol sideband outputs.
module padding_stream
  import conv_pkg::*;
#(
  parameter int unsigned W          = 220,
  parameter int unsigned H          = 220,
  parameter int unsigned P          = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
`ifdef PADDING_MARKERS_EN
  ,
  output logic                  out_sof,
  output logic                  out_eol
`endif
);

  logic interior_c;
  logic last_col_c;
  logic last_pixel_c;
  logic can_load_c;
  logic load_c;
  logic out_last;
`ifdef PADDING_MARKERS_EN
  logic first_c;
`endif

  padding_pos_cnt #(
    .W(W),
    .H(H),
    .P(P)
  ) u_pos (
    .clk         (clk),
    .reset       (reset),
    .advance     (load_c),
    .interior_c  (interior_c),
`ifdef PADDING_MARKERS_EN
    .first_c     (first_c),
`endif
    .last_col_c  (last_col_c),
    .last_pixel_c(last_pixel_c)
  );

  // Border positions load unconditionally; interior positions wait for the source.
  assign can_load_c = !out_valid || out_ready;
  assign load_c     = !reset && can_load_c && (!interior_c || in_valid);
  assign in_ready   = !reset && interior_c && can_load_c;
  assign frame_done = !reset && out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_out   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef PADDING_MARKERS_EN
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
`endif
    end else if (load_c) begin
      pxl_out   <= interior_c ? pxl_in : PAD_VALUE;
      out_valid <= 1'b1;
      out_last  <= last_pixel_c;
`ifdef PADDING_MARKERS_EN
      out_sof   <= first_c;
      out_eol   <= last_col_c;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_padding_stream.sv
// Scoreboard bench for padding_stream: three 4x4 instances (P=1, P=2, all-ones pad).
module tb_padding_stream;

  localparam int unsigned NI = 3;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned P_A [NI] = '{1, 2, 1};
  localparam logic [DW-1:0] PAD_A [NI] = '{32'h0, 32'h0, 32'hFFFF_FFFF};

  typedef struct {
    logic [DW-1:0] pix;
    logic          last;
    logic          sof;
    logic          eol;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset      [NI];
  logic [DW-1:0] pxl_in     [NI];
  logic          in_valid   [NI];
  logic          in_ready   [NI];
  logic [DW-1:0] pxl_out    [NI];
  logic          out_valid  [NI];
  logic          out_ready  [NI];
  logic          frame_done [NI];
`ifdef PADDING_MARKERS_EN
  logic          out_sof    [NI];
  logic          out_eol    [NI];
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    padding_stream #(
      .W(W),
      .H(H),
      .P(P_A[g]),
      .DATA_WIDTH(DW),
      .PAD_VALUE(PAD_A[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .pxl_in    (pxl_in[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .pxl_out   (pxl_out[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .frame_done(frame_done[g])
`ifdef PADDING_MARKERS_EN
      ,
      .out_sof   (out_sof[g]),
      .out_eol   (out_eol[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected padded frames; interior positions take consecutive source values.
  task automatic push_frames(input int k, input int frames, inout int unsigned val);
    int unsigned p  = P_A[k];
    int unsigned pw = W + 2 * p;
    int unsigned ph = H + 2 * p;
    exp_t e;
    for (int f = 0; f < frames; f++)
      for (int unsigned r = 0; r < ph; r++)
        for (int unsigned c = 0; c < pw; c++) begin
          if (r >= p && r < p + H && c >= p && c < p + W) begin
            e.pix = val;
            val++;
          end else begin
            e.pix = PAD_A[k];
          end
          e.last = (r == ph - 1) && (c == pw - 1);
          e.sof  = (r == 0) && (c == 0);
          e.eol  = (c == pw - 1);
          sb.push_back(e);
        end
  endtask

  task automatic run(input int k, input int frames, input bit rdy_toggle, input bit gaps,
                     input int rst_at);
    int unsigned   nxt = 1;
    int unsigned   exp_val = 1;
    int            outs = 0;
    int            ins = 0;
    int            cyc = 0;
    int            first_cyc = -1;
    int            last_cyc = 0;
    int            exp_ins = W * H * frames;
    logic [DW-1:0] prev_pix = '0;
    bit            prev_stall = 0;
    bit            pend = 0;
    bit            done_rst = 0;
    bit            post_rst = 0;
    exp_t          e;

    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    pxl_in[k]    = '0;
    @(negedge clk);
    reset[k] = 1'b1;
    @(negedge clk);
    #1;
    check("rst_ov", out_valid[k], 0);
    check("rst_pix", pxl_out[k], 0);
    check("rst_in_ready", in_ready[k], 0);
    check("rst_fd", frame_done[k], 0);

    sb.delete();
    push_frames(k, frames, exp_val);
    while (sb.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (rst_at >= 0 && !done_rst && outs == rst_at) begin
        reset[k] = 1'b1;
        done_rst = 1;
      end else begin
        reset[k] = 1'b0;
      end
      out_ready[k] = rdy_toggle ? (cyc % 2 == 1) : 1'b1;
      if (!pend) in_valid[k] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pxl_in[k] = nxt;
      #1;
      if (reset[k]) begin
        check("mid_rst_in_ready", in_ready[k], 0);
        check("mid_rst_fd", frame_done[k], 0);
        sb.delete();
        exp_val = 1;
        push_frames(k, 1, exp_val);
        nxt = 1;
        ins = 0;
        outs = 0;
        exp_ins = W * H;
        first_cyc = -1;
        pend = 0;
        prev_stall = 0;
        post_rst = 1;
      end else begin
        if (post_rst) begin
          check("post_rst_ov", out_valid[k], 0);
          check("post_rst_pix", pxl_out[k], 0);
          post_rst = 0;
        end
        if (prev_stall && out_valid[k]) check("stall_hold", pxl_out[k], prev_pix);
        if (out_valid[k] && out_ready[k]) begin
          e = sb.pop_front();
          check("pix", pxl_out[k], e.pix);
          check("fd", frame_done[k], e.last);
`ifdef PADDING_MARKERS_EN
          check("sof", out_sof[k], e.sof);
          check("eol", out_eol[k], e.eol);
`endif
          outs++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end else begin
          check("fd_idle", frame_done[k], 0);
        end
        if (in_valid[k] && in_ready[k]) begin
          ins++;
          nxt++;
          pend = 0;
        end else begin
          pend = in_valid[k];
        end
        prev_stall = out_valid[k] && !out_ready[k];
        prev_pix   = pxl_out[k];
      end
    end
    check("timeout_left", sb.size(), 0);
    check("in_handshakes", ins, exp_ins);
    if (!rdy_toggle && !gaps) check("throughput", last_cyc - first_cyc + 1, outs);
    @(negedge clk);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    reset[k]     = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      reset[i]     = 1'b1;
      pxl_in[i]    = '0;
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
    run(0, 1, 1'b0, 1'b0, -1);
    run(1, 1, 1'b0, 1'b0, -1);
    run(0, 1, 1'b1, 1'b1, -1);
    run(0, 1, 1'b0, 1'b0, 20);
    run(2, 2, 1'b0, 1'b0, -1);
    run(1, 2, 1'b1, 1'b1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
